pipelined_alu: RTL and testbench
================================

# pipelined_alu

Parametrised, registered successor to the datapath ALU. Executes the existing single-cycle operations (bypass, add, subtract, and, or, xor) and adds barrel shifts and an iterative multiply. Sits between the register-read and memory stages of the CPU pipeline. Valid/ready handshakes on both sides let the multi-cycle multiply stall the pipeline cleanly.

## Interface
- WIDTH, 64, operand/result width in bits; must be ≥ 8 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset; one clock domain.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block can accept this cycle.
- op  in  4  operation code (see Operation).
- A, B  in  WIDTH  operands.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  downstream consumes the result.
- result  out  WIDTH  registered result.
- negative, zero, overflow, carry_out  out  1 each  registered flags, aligned with result.
- illegal  out  1  registered; set when the accepted op was unassigned.

## Operation
- Op codes:
  - 0000 BYPASS: B.
  - 0010 ADD: A+B.
  - 0011 SUB: A+~B+1.
  - 0100 AND, 0101 OR, 0110 XOR.
  - 1000 LSL: A<<B[SHW-1:0].
  - 1001 LSR: logical right shift, same amount.
  - 1010 ASR: arithmetic right shift, same amount.
  - 1011 MUL: low WIDTH bits of A*B, unsigned.
  - All other codes are illegal: result 0, illegal=1, flags derived from the zero result.
- Flags:
  - negative=result[WIDTH-1]; zero=(result==0).
  - ADD/SUB: carry_out = carry out of bit WIDTH-1; overflow = carry into MSB XOR carry out of MSB.
  - All other ops: overflow=0, carry_out=0.
- Transfer happens when in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- State machine:
  - IDLE: a non-MUL op loads the output register at the accepting edge. A MUL op latches A and B, clears count, and moves to MUL.
  - MUL: one shift-add step per cycle; count increments 0..WIDTH-1. At count==WIDTH-1, if !out_valid || out_ready, load the product into the output register and return to IDLE. Otherwise hold count and the partial product until the register frees.
- Output register: out_valid clears on out_valid && out_ready unless a new load occurs the same edge; a same-edge load keeps out_valid=1 with the new data.
- Reset (any time, including mid-MUL): state=IDLE, count=0. Outputs reset to out_valid=0, result=0, negative=0, zero=0, overflow=0, carry_out=0, illegal=0. The partial product is discarded.
- Inputs while !in_ready are ignored; the upstream stage holds them.

## Timing
- Non-MUL latency: 1 cycle; accept at edge k, out_valid=1 after edge k.
- MUL latency: WIDTH cycles; accept at edge k, result after edge k+WIDTH with no back-pressure. Each back-pressured cycle at the final step adds one.
- Throughput: one non-MUL op per cycle with out_ready held high. MUL blocks new acceptance until it loads the output register.
- in_ready is combinational from state, out_valid and out_ready. It has no path from in_valid.

## Configuration
- ALU_MUL_EN defined: MUL op (1011) is implemented as above.
- ALU_MUL_EN undefined:
  - 1011 is treated as illegal (result 0, illegal=1, 1-cycle latency).
  - No MUL state, counter or multiplier registers are synthesised.

## Structure
- Package alu_pkg holds:
  - the op_t enum (4-bit codes above);
  - the MUL state enum (IDLE, MUL);
  - a function computing negative/zero from a result.
- Sub-module mul_iter: WIDTH-parametrised shift-add multiplier with start/step/done. Instantiated only under ALU_MUL_EN.
- Adder, logic and shifter paths stay in the top level as combinational logic feeding the output register.

## Test plan
- WIDTH=64, ADD A=64'h7FFF_FFFF_FFFF_FFFF, B=1, out_ready=1 -> next cycle result=64'h8000_0000_0000_0000, negative=1, overflow=1, carry_out=0, zero=0.
- SUB A=5, B=5 -> result=0, zero=1, carry_out=1, overflow=0. Then back-to-back AND/OR/XOR with A=F0, B=3C give 30, FC, CC on consecutive cycles.
- ASR A=64'h8000_0000_0000_0000, B=63 -> result=all ones, negative=1. LSL with B=64 uses amount 0 -> result=A.
- MUL A=12345, B=678 with ALU_MUL_EN -> in_ready=0 for 64 cycles, result=8369910, out_valid after edge k+64. With out_ready=0 for 5 cycles, completion is delayed 5 cycles and the value is unchanged.
- Illegal op 0111 -> result=0, illegal=1, zero=1. Without ALU_MUL_EN, op 1011 gives the same response in 1 cycle.
- Assert reset_n low 10 cycles into a MUL -> out_valid=0 and in_ready=1 immediately after release. A following ADD 2+3 gives 5 with no stale product.

Source files
------------

// File: rtl/pipelined_alu_pkg.sv
// alu_pkg: op codes, MUL sequencer states and the negative/zero flag helper
// shared by pipelined_alu and its iterative multiplier.
package alu_pkg;

  // Upper bound on WIDTH accepted by the flag helper.
  localparam int MAX_WIDTH = 1024;
  localparam int MAX_SHW   = 10;

  typedef enum logic [3:0] {
    OP_BYPASS = 4'b0000,
    OP_ADD    = 4'b0010,
    OP_SUB    = 4'b0011,
    OP_AND    = 4'b0100,
    OP_OR     = 4'b0101,
    OP_XOR    = 4'b0110,
    OP_LSL    = 4'b1000,
    OP_LSR    = 4'b1001,
    OP_ASR    = 4'b1010,
    OP_MUL    = 4'b1011
  } op_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } mul_state_t;

  typedef struct packed {
    logic negative;
    logic zero;
  } nz_t;

  // res is the zero-extended result; msb is the index of the real sign bit.
  function automatic nz_t calc_nz(input logic [MAX_WIDTH-1:0] res,
                                  input logic [MAX_SHW-1:0]   msb);
    nz_t f;
    f.negative = res[msb];
    f.zero     = (res == {MAX_WIDTH{1'b0}});
    return f;
  endfunction

endpackage

// File: rtl/pipelined_alu_mul_iter.sv
// mul_iter: WIDTH-step shift-add multiplier producing the low WIDTH bits of a*b.
// product always shows the accumulator value that the current step would produce.
module mul_iter #(
  parameter  int WIDTH = 64,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_r;
  logic [SHW-1:0]   count_r;
  logic [WIDTH-1:0] addend_s;

  // Partial product after the current step and last-step detection.
  always_comb begin
    addend_s = mplier_r[0] ? mcand_r : {WIDTH{1'b0}};
    product  = acc_r + addend_s;
    done     = (count_r == SHW'(WIDTH - 1));
  end

  // Operand latch on start, one shift-add per step; held when neither is asserted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      count_r  <= {SHW{1'b0}};
    end else if (start) begin
      mcand_r  <= a;
      mplier_r <= b;
      acc_r    <= {WIDTH{1'b0}};
      count_r  <= {SHW{1'b0}};
    end else if (step) begin
      acc_r    <= product;
      mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      count_r  <= done ? {SHW{1'b0}} : count_r + SHW'(1);
    end
  end

endmodule

// File: rtl/pipelined_alu.sv
// pipelined_alu: registered ALU stage with valid/ready handshakes on both sides.
// Define ALU_MUL_EN to build the iterative MUL (op 1011); otherwise 1011 is illegal.
module pipelined_alu
  import alu_pkg::*;
#(
  parameter  int WIDTH = 64,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic             illegal
);

  logic             out_free_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             alu_load_s;
  logic             mul_load_s;
  logic             load_s;

  logic             cin_s;
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   sum_s;
  logic             carry_msb_in_s;
  logic [SHW-1:0]   shamt_s;

  logic [WIDTH-1:0] alu_res_s;
  logic             alu_ovf_s;
  logic             alu_cout_s;
  logic             alu_ill_s;

  logic [WIDTH-1:0] ld_res_s;
  logic             ld_ovf_s;
  logic             ld_cout_s;
  logic             ld_ill_s;
  nz_t              ld_nz_s;

  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic             negative_r;
  logic             zero_r;
  logic             overflow_r;
  logic             carry_out_r;
  logic             illegal_r;

  assign out_free_s = !out_valid_r || out_ready;
  assign accept_s   = in_valid && in_ready_s;
  assign load_s     = alu_load_s || mul_load_s;

  // Shared adder: SUB is A + ~B + 1, carry into the MSB recovered from the sum bit.
  always_comb begin
    cin_s          = (op == OP_SUB);
    b_eff_s        = cin_s ? ~B : B;
    sum_s          = {1'b0, A} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, cin_s};
    carry_msb_in_s = sum_s[WIDTH-1] ^ A[WIDTH-1] ^ b_eff_s[WIDTH-1];
    shamt_s        = B[SHW-1:0];
  end

  // Single-cycle result and flags for every op except MUL.
  always_comb begin
    alu_res_s  = {WIDTH{1'b0}};
    alu_ovf_s  = 1'b0;
    alu_cout_s = 1'b0;
    alu_ill_s  = 1'b0;
    case (op)
      OP_BYPASS: alu_res_s = B;
      OP_ADD, OP_SUB: begin
        alu_res_s  = sum_s[WIDTH-1:0];
        alu_cout_s = sum_s[WIDTH];
        alu_ovf_s  = carry_msb_in_s ^ sum_s[WIDTH];
      end
      OP_AND:    alu_res_s = A & B;
      OP_OR:     alu_res_s = A | B;
      OP_XOR:    alu_res_s = A ^ B;
      OP_LSL:    alu_res_s = A << shamt_s;
      OP_LSR:    alu_res_s = A >> shamt_s;
      OP_ASR:    alu_res_s = $signed(A) >>> shamt_s;
`ifdef ALU_MUL_EN
      // Legal, but its result comes from the multiplier, not this path.
      OP_MUL:    alu_ill_s = 1'b0;
`endif
      default:   alu_ill_s = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  mul_state_t       state_r;
  mul_state_t       next_state_s;
  logic             is_mul_s;
  logic             mul_start_s;
  logic             mul_step_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] mul_product_s;

  assign is_mul_s   = (op == OP_MUL);
  assign alu_load_s = accept_s && !is_mul_s;

  mul_iter #(.WIDTH(WIDTH)) u_mul_iter (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start_s),
    .step    (mul_step_s),
    .a       (A),
    .b       (B),
    .done    (mul_done_s),
    .product (mul_product_s)
  );

  // MUL sequencer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // MUL sequencer next state; the last step waits for a free output register.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && out_free_s && is_mul_s) begin
          next_state_s = ST_MUL;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_done_s && out_free_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_MUL;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // MUL sequencer outputs; start is written without accept_s to keep in_ready loop-free.
  always_comb begin
    in_ready_s  = 1'b0;
    mul_start_s = 1'b0;
    mul_step_s  = 1'b0;
    mul_load_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready_s  = out_free_s;
        mul_start_s = in_valid && out_free_s && is_mul_s;
      end
      ST_MUL: begin
        mul_step_s = !mul_done_s || out_free_s;
        mul_load_s = mul_done_s && out_free_s;
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
  end

  // Output-register load data: product from the multiplier or the ALU path.
  always_comb begin
    if (mul_load_s) begin
      ld_res_s  = mul_product_s;
      ld_ovf_s  = 1'b0;
      ld_cout_s = 1'b0;
      ld_ill_s  = 1'b0;
    end else begin
      ld_res_s  = alu_res_s;
      ld_ovf_s  = alu_ovf_s;
      ld_cout_s = alu_cout_s;
      ld_ill_s  = alu_ill_s;
    end
    ld_nz_s = calc_nz(MAX_WIDTH'(ld_res_s), MAX_SHW'(WIDTH - 1));
  end
`else
  assign in_ready_s = out_free_s;
  assign alu_load_s = accept_s;
  assign mul_load_s = 1'b0;

  // Output-register load data straight from the ALU path.
  always_comb begin
    ld_res_s  = alu_res_s;
    ld_ovf_s  = alu_ovf_s;
    ld_cout_s = alu_cout_s;
    ld_ill_s  = alu_ill_s;
    ld_nz_s   = calc_nz(MAX_WIDTH'(ld_res_s), MAX_SHW'(WIDTH - 1));
  end
`endif

  // Output register: a load wins over same-edge consumption.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      negative_r  <= 1'b0;
      zero_r      <= 1'b0;
      overflow_r  <= 1'b0;
      carry_out_r <= 1'b0;
      illegal_r   <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      result_r    <= ld_res_s;
      negative_r  <= ld_nz_s.negative;
      zero_r      <= ld_nz_s.zero;
      overflow_r  <= ld_ovf_s;
      carry_out_r <= ld_cout_s;
      illegal_r   <= ld_ill_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign negative  = negative_r;
  assign zero      = zero_r;
  assign overflow  = overflow_r;
  assign carry_out = carry_out_r;
  assign illegal   = illegal_r;

endmodule

// File: tb/tb_pipelined_alu.sv
// tb_pipelined_alu: directed vector table, MUL/reset sequences and a randomized
// run against an arithmetic reference model of pipelined_alu (WIDTH=64).
module tb_pipelined_alu;

  localparam int W = 64;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] res;
    logic         n;
    logic         z;
    logic         v;
    logic         c;
    logic         ill;
  } resp_t;

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    resp_t        exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, negative, zero, overflow, carry_out, illegal;
  logic [W-1:0] result;
  resp_t        obs;

  int errors = 0;
  int checks = 0;

  assign obs = {result, negative, zero, overflow, carry_out, illegal};

  pipelined_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .negative(negative), .zero(zero), .overflow(overflow),
    .carry_out(carry_out), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_resp(input string name, input resp_t act, input resp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got res=%h nzvc=%b%b%b%b ill=%b, expected res=%h nzvc=%b%b%b%b ill=%b",
               name, act.res, act.n, act.z, act.v, act.c, act.ill,
               exp.res, exp.n, exp.z, exp.v, exp.c, exp.ill);
    end
  endtask

  // Reference: plain arithmetic on the operands, signed overflow from operand signs.
  function automatic resp_t ref_alu(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    resp_t      r;
    logic [W:0] wide;
    int         sh;
    r  = '0;
    sh = int'(y[5:0]);
    case (o)
      4'd0: r.res = y;
      4'd2: begin
        wide  = {1'b0, x} + {1'b0, y};
        r.res = wide[W-1:0];
        r.c   = wide[W];
        r.v   = (x[W-1] == y[W-1]) && (r.res[W-1] != x[W-1]);
      end
      4'd3: begin
        wide  = {1'b0, x} + {1'b0, ~y} + 65'd1;
        r.res = wide[W-1:0];
        r.c   = wide[W];
        r.v   = (x[W-1] != y[W-1]) && (r.res[W-1] != x[W-1]);
      end
      4'd4: r.res = x & y;
      4'd5: r.res = x | y;
      4'd6: r.res = x ^ y;
      4'd8: r.res = x << sh;
      4'd9: r.res = x >> sh;
      4'd10: r.res = (x >> sh) | (x[W-1] ? ~({W{1'b1}} >> sh) : {W{1'b0}});
      4'd11: begin
        if (MUL_EN) r.res = x * y;
        else        r.ill = 1'b1;
      end
      default: r.ill = 1'b1;
    endcase
    r.n = r.res[W-1];
    r.z = (r.res == '0);
    return r;
  endfunction

  function automatic vec_t mk(input string nm, input logic [3:0] o, input logic [W-1:0] x,
                              input logic [W-1:0] y, input logic [W-1:0] r,
                              input logic n, input logic z, input logic v, input logic c,
                              input logic ill);
    vec_t t;
    t.name = nm; t.op = o; t.a = x; t.b = y;
    t.exp  = {r, n, z, v, c, ill};
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t  vecs[$];
    resp_t exp_r, mul_r, m_resp, nresp;
    int    lat, ready_hi, busy, stale;
    logic  m_valid, exp_ready, loaded;
    logic [3:0] o;

    vecs.push_back(mk("add_ovf",   4'd2,  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk("sub_eq",    4'd3,  64'd5, 64'd5, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk("and",       4'd4,  64'hF0, 64'h3C, 64'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("or",        4'd5,  64'hF0, 64'h3C, 64'hFC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("xor",       4'd6,  64'hF0, 64'h3C, 64'hCC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("asr63",     4'd10, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("lsl64",     4'd8,  64'h1234, 64'd64, 64'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("lsr4",      4'd9,  64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("bypass0",   4'd0,  64'd1, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("ill_0111",  4'd7,  64'd5, 64'd6, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk("add_wrap",  4'd2,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk("sub_borrow",4'd3,  64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("sub_ovf",   4'd3,  64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
`ifndef ALU_MUL_EN
    vecs.push_back(mk("mul_ill",   4'd11, 64'd12345, 64'd678, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
`endif

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_resp("rst_outputs", obs, '0);
    check_bit("rst_in_ready", in_ready, 1'b1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, back to back
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      in_valid = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      check_bit({vecs[i].name, "_in_ready"}, in_ready, 1'b1);
      @(posedge clk);
      #1;
      check_bit({vecs[i].name, "_valid"}, out_valid, 1'b1);
      check_resp(vecs[i].name, obs, vecs[i].exp);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_bit("drain_valid", out_valid, 1'b0);

`ifdef ALU_MUL_EN
    // MUL latency and in_ready blocking
    in_valid = 1'b1; op = 4'd11; a = 64'd12345; b = 64'd678;
    @(posedge clk);
    #1;
    in_valid = 1'b0; op = 4'd0;
    lat = 0; ready_hi = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) ready_hi++;
      @(posedge clk);
      #1;
      lat++;
    end
    check_int("mul_latency", lat, 64);
    check_int("mul_ready_high_cycles", ready_hi, 0);
    check_resp("mul_12345x678", obs, {64'd8369910, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

    // MUL result held under back-pressure
    in_valid = 1'b1; op = 4'd11; a = {$urandom, $urandom}; b = {$urandom, $urandom};
    mul_r = ref_alu(4'd11, a, b);
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_int("mul_bp_latency", lat, 64);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check_bit("mul_bp_hold_valid", out_valid, 1'b1);
      check_bit("mul_bp_in_ready", in_ready, 1'b0);
      check_resp("mul_bp_hold", obs, mul_r);
    end
    out_ready = 1'b1;
    #1;
    check_bit("mul_bp_release_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    check_bit("mul_bp_consumed", out_valid, 1'b0);
`endif

    // Reset in the middle of a MUL
    in_valid = 1'b1; op = 4'd11; a = 64'd1000; b = 64'd1000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_bit("midmul_rst_async_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check_bit("midmul_out_valid", out_valid, 1'b0);
    check_bit("midmul_in_ready", in_ready, 1'b1);
    in_valid = 1'b1; op = 4'd2; a = 64'd2; b = 64'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_bit("post_rst_add_valid", out_valid, 1'b1);
    check_resp("post_rst_add", obs, {64'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    stale = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    check_int("no_stale_product", stale, 0);

    // Randomized run against the reference model
    m_valid = 1'b0; busy = 0; m_resp = '0; mul_r = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      o = 4'($urandom_range(0, 15));
      if (o == 4'd11 && $urandom_range(0, 3) != 0) o = 4'd2;
      op = o;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) b = 64'($urandom_range(0, 70));
      out_ready = ($urandom_range(0, 3) != 0);
      exp_ready = (busy == 0) && (!m_valid || out_ready);
      #1;
      check_bit("rnd_in_ready", in_ready, exp_ready);
      @(posedge clk);
      nresp  = ref_alu(op, a, b);
      loaded = 1'b0;
      if (busy == 0) begin
        if (in_valid && exp_ready) begin
          if (MUL_EN && op == 4'd11) begin
            busy  = W;
            mul_r = nresp;
          end else begin
            m_valid = 1'b1; m_resp = nresp; loaded = 1'b1;
          end
        end
      end else if (busy == 1) begin
        if (!m_valid || out_ready) begin
          m_valid = 1'b1; m_resp = mul_r; busy = 0; loaded = 1'b1;
        end
      end else begin
        busy--;
      end
      if (!loaded && m_valid && out_ready) m_valid = 1'b0;
      #1;
      check_bit("rnd_out_valid", out_valid, m_valid);
      if (m_valid) begin
        exp_r = m_resp;
        check_resp("rnd_result", obs, exp_r);
      end
    end
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
